tx: RTL and testbench
=====================

TX -- requirements
Module: tx

Interface
REQ-001 Parameter ID, default 0, instance number used in debug trace prefix.
REQ-002 Parameter MOD_NAME, default "TX", module label used in debug trace prefix.
REQ-003 Parameter SIZE, default 8, flit width in bits.
REQ-004 Parameter BUFF_BITS, default 3, packet buffer address bits; FLIT_COUNT = 2**BUFF_BITS flits per packet.
REQ-005 One clock; reset is asynchronous and active-low. Ports are clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 pkt_req  input  1  switch level request: a full packet is readable at buf_data.
REQ-009 pkt_done  output  1  level: packet fully sent; held until pkt_req falls.
REQ-010 buf_addr  output  BUFF_BITS  flit index presented to the source packet buffer.
REQ-011 buf_data  input  SIZE  combinational flit read from the source buffer at buf_addr.
REQ-012 ch_req  output  1  two-phase request: each toggle announces a new ch_flit.
REQ-013 ch_flit  output  SIZE  registered flit, stable from the ch_req toggle until the matching ch_ack toggle.
REQ-014 ch_ack  input  1  two-phase acknowledge: each toggle completes one flit transfer.

Function
REQ-015 FSM states: ST_IDLE, ST_FETCH, ST_SEND, ST_WAIT_ACK, ST_DONE.
REQ-016 ack event = ch_ack XOR ch_ack_old; ch_ack_old is registered from ch_ack every cycle.
REQ-017 ST_IDLE: when pkt_req=1, go to ST_FETCH with flit_counter=0 and buf_addr=0.
REQ-018 ST_FETCH: one cycle; latch ch_flit <= buf_data; go to ST_SEND.
REQ-019 ST_SEND: toggle ch_req; go to ST_WAIT_ACK. This gives two cycles from the ST_FETCH entry to the ch_req edge.
REQ-020 ST_WAIT_ACK: hold ch_flit, ch_req, and buf_addr until an ack event occurs.
REQ-021 On an ack event with flit_counter < FLIT_COUNT-1: increment flit_counter and buf_addr, then go to ST_FETCH.
REQ-022 On an ack event with flit_counter = FLIT_COUNT-1: set pkt_done=1 and go to ST_DONE.
REQ-023 ST_DONE: when pkt_req=0, clear pkt_done, reset flit_counter and buf_addr to 0, and go to ST_IDLE.
REQ-024 Only one flit is outstanding at a time; ch_req never toggles twice without an intervening ack event.
REQ-025 An ack event in any state other than ST_WAIT_ACK is ignored and has no state change.
REQ-026 pkt_req falling before ST_DONE is ignored; the packet always completes.
REQ-027 flit_counter is BUFF_BITS+1 bits wide; buf_addr equals its low BUFF_BITS bits and never wraps mid-packet.
REQ-028 Sustained throughput is one flit per 3 cycles plus channel ack latency.

Reset
REQ-029 While reset=0: state=ST_IDLE, ch_req=0, ch_flit=0, pkt_done=0, buf_addr=0, flit_counter=0, ch_ack_old=0.
REQ-030 Reset asserted mid-packet aborts the transfer immediately; no partial-packet recovery.
REQ-031 After reset release, the first ack event is evaluated only after one clock, once ch_ack_old has sampled ch_ack.

Configuration
REQ-032 Macro TX_DEBUG_TRACE_EN, when defined, compiles in a $display trace with prefix (MOD_NAME, ID) through the shared debug tasks.
REQ-033 The trace reports: packet start, each flit sent (index and hex value), each ack, packet complete, and each ignored spurious ack.
REQ-034 With the macro undefined, no trace code is compiled, and cycle behaviour is identical.

Structure
REQ-035 State encodings and the two-phase event helper belong in a shared noc package, which rx also uses.
REQ-036 Sub-module: tp_edge_det (two-phase toggle detector, registered old value plus XOR), shared with the receive side.
REQ-037 The buffer storage is external; tx contains no flit memory beyond ch_flit.

Verification
REQ-038 Buffer = 0x80,0x01..0x07; pkt_req=1; responder acks 1 cycle after each toggle -> 8 ch_req toggles, ch_flit sequence 0x80,0x01..0x07, then pkt_done=1.
REQ-039 Responder acks 10 cycles after a toggle -> ch_flit and ch_req are held stable for all 10 cycles; no second toggle occurs.
REQ-040 Extra ch_ack toggle injected in ST_IDLE -> no ch_req activity and state stays ST_IDLE.
REQ-041 pkt_req held high after pkt_done -> tx stays in ST_DONE; pkt_req dropped -> pkt_done=0 next cycle, then a new pkt_req restarts from buf_addr=0.
REQ-042 reset=0 after flit 4 is acked -> all outputs return to their reset values; the next packet starts at buf_addr=0.
REQ-043 tx connected back-to-back to rx with SINK_PACKETS=1 -> rx consumes a packet identical to the tx source buffer.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg -- shared definitions for the two-phase NoC link (tx and rx sides).
//   * noc_state_e : link FSM state encoding
//   * tp_event()  : two-phase handshake event helper (current XOR previous)
//   * dbg_trace() : debug trace task, compiled only when TX_DEBUG_TRACE_EN
//                   is defined
// -----------------------------------------------------------------------------
package noc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_SEND     = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4
   } noc_state_e;

   // A two-phase event is any level change of the handshake wire.
   function automatic logic tp_event(input logic cur, input logic old);
      return cur ^ old;
   endfunction

`ifdef TX_DEBUG_TRACE_EN
   task automatic dbg_trace(input string mod_name, input int id, input string msg);
      $display("[%s%0d] %0t: %s", mod_name, id, $time, msg);
   endtask
`endif

endpackage

// File: rtl/tp_edge_det.sv
// -----------------------------------------------------------------------------
// tp_edge_det -- two-phase toggle detector.
//   clk      in  rising-edge clock
//   reset    in  asynchronous active-low reset (old value clears to 0)
//   tp_in    in  two-phase handshake wire
//   tp_evt   out 1 for the cycle in which tp_in differs from its last sample
// -----------------------------------------------------------------------------
module tp_edge_det
   import noc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic tp_in,
   output logic tp_evt
);

   logic old_q;
   logic old_d;

   // Next sample of the handshake wire.
   always_comb begin
      old_d = tp_in;
   end

   // Previous-value register, sampled every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         old_q <= 1'b0;
      end else begin
         old_q <= old_d;
      end
   end

   // Event when the wire has moved since the last sample.
   always_comb begin
      tp_evt = tp_event(tp_in, old_q);
   end

endmodule

// File: rtl/tx.sv
// -----------------------------------------------------------------------------
// tx -- packet transmitter over a two-phase request/acknowledge flit channel.
// Reads FLIT_COUNT = 2**BUFF_BITS flits from an external buffer and sends them
// one at a time; a single flit is outstanding at any moment.
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   pkt_req   in   level: a full packet is readable at buf_data
//   pkt_done  out  level: packet sent, held until pkt_req falls
//   buf_addr  out  flit index presented to the source buffer
//   buf_data  in   combinational flit read at buf_addr
//   ch_req    out  two-phase request, toggles once per flit
//   ch_flit   out  registered flit, stable while its request is outstanding
//   ch_ack    in   two-phase acknowledge
// Optional build macro: TX_DEBUG_TRACE_EN adds a $display activity trace.
// -----------------------------------------------------------------------------
module tx
   import noc_pkg::*;
#(
   parameter int ID        = 0,
   parameter     MOD_NAME  = "TX",
   parameter int SIZE      = 8,
   parameter int BUFF_BITS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pkt_req,
   output logic                 pkt_done,
   output logic [BUFF_BITS-1:0] buf_addr,
   input  logic [SIZE-1:0]      buf_data,
   output logic                 ch_req,
   output logic [SIZE-1:0]      ch_flit,
   input  logic                 ch_ack
);

   localparam int FLIT_COUNT = 2**BUFF_BITS;
   localparam logic [BUFF_BITS:0] LAST_FLIT = (BUFF_BITS+1)'(FLIT_COUNT - 1);
   localparam logic [BUFF_BITS:0] CNT_ONE   = (BUFF_BITS+1)'(1);

   noc_state_e           state_q, state_d;
   logic [BUFF_BITS:0]   cnt_q, cnt_d;
   logic                 ch_req_q, ch_req_d;
   logic [SIZE-1:0]      ch_flit_q, ch_flit_d;
   logic                 pkt_done_q, pkt_done_d;
   logic                 ack_evt;

   tp_edge_det u_ack_det (
      .clk    (clk),
      .reset  (reset),
      .tp_in  (ch_ack),
      .tp_evt (ack_evt)
   );

   // Next-state and datapath; acks outside ST_WAIT_ACK fall through unused.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ch_req_d   = ch_req_q;
      ch_flit_d  = ch_flit_q;
      pkt_done_d = pkt_done_q;
      case (state_q)
         ST_IDLE: begin
            if (pkt_req) begin
               cnt_d   = '0;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            ch_flit_d = buf_data;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            ch_req_d = ~ch_req_q;
            state_d  = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (ack_evt) begin
               if (cnt_q == LAST_FLIT) begin
                  // Counter stays on the last index so buf_addr never wraps.
                  pkt_done_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_WAIT_ACK;
            end
         end
         ST_DONE: begin
            if (!pkt_req) begin
               pkt_done_d = 1'b0;
               cnt_d      = '0;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            pkt_done_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ch_req_q   <= 1'b0;
         ch_flit_q  <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ch_req_q   <= ch_req_d;
         ch_flit_q  <= ch_flit_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   assign pkt_done = pkt_done_q;
   assign buf_addr = cnt_q[BUFF_BITS-1:0];
   assign ch_req   = ch_req_q;
   assign ch_flit  = ch_flit_q;

`ifdef TX_DEBUG_TRACE_EN
   // Activity trace, observed on the same edges that move the FSM.
   always @(posedge clk) begin
      if (reset) begin
         if (state_q == ST_IDLE && pkt_req)
            dbg_trace(MOD_NAME, ID, "packet start");
         if (state_q == ST_SEND)
            dbg_trace(MOD_NAME, ID, $sformatf("flit %0d sent 0x%h", cnt_q, ch_flit_q));
         if (state_q == ST_WAIT_ACK && ack_evt)
            dbg_trace(MOD_NAME, ID, $sformatf("ack flit %0d", cnt_q));
         if (state_q == ST_WAIT_ACK && ack_evt && cnt_q == LAST_FLIT)
            dbg_trace(MOD_NAME, ID, "packet complete");
         if (state_q != ST_WAIT_ACK && ack_evt)
            dbg_trace(MOD_NAME, ID, "spurious ack ignored");
      end
   end
`endif

endmodule

// File: tb/tb_tx.sv
// -----------------------------------------------------------------------------
// tb_tx -- self-checking bench for tx. A packet-level model predicts, for every
// cycle, pkt_done, buf_addr, ch_req and the outstanding ch_flit; a few literal
// expectations pin the flit sequence and hold behaviour.
// -----------------------------------------------------------------------------
module tb_tx;

   localparam int SIZE      = 8;
   localparam int BUFF_BITS = 3;
   localparam int NFLIT     = 2**BUFF_BITS;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 pkt_req;
   logic                 pkt_done;
   logic [BUFF_BITS-1:0] buf_addr;
   logic [SIZE-1:0]      buf_data;
   logic                 ch_req;
   logic [SIZE-1:0]      ch_flit;
   logic                 ch_ack;

   logic [SIZE-1:0] mem  [NFLIT];
   logic [SIZE-1:0] exp1 [NFLIT] = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
   logic [SIZE-1:0] exp2 [NFLIT] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h11, 8'hEE};

   int n_checks = 0;
   int n_fail   = 0;

   // responder / monitor state (all owned by the initial block)
   int          ack_delay = 1;
   int          resp_cnt  = 0;
   logic        resp_seen = 1'b0;
   logic        inject_ack = 1'b0;
   logic        mon_prev = 1'b0;
   logic [SIZE-1:0] got [$];

   // packet-level model state
   logic                 m_ack_prev;
   logic                 m_done;
   logic                 m_wait;
   logic [1:0]           m_cd;
   logic [BUFF_BITS:0]   m_idx;
   logic                 m_req;
   logic [SIZE-1:0]      m_flit;

   always #5 clk = ~clk;

   assign buf_data = mem[buf_addr];

   tx #(.ID(0), .MOD_NAME("TX"), .SIZE(SIZE), .BUFF_BITS(BUFF_BITS)) dut (
      .clk      (clk),
      .reset    (reset),
      .pkt_req  (pkt_req),
      .pkt_done (pkt_done),
      .buf_addr (buf_addr),
      .buf_data (buf_data),
      .ch_req   (ch_req),
      .ch_flit  (ch_flit),
      .ch_ack   (ch_ack)
   );

   // Model: a flit goes out two cycles after the packet starts or after the
   // previous flit's ack; the packet finishes on the last ack.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ack_prev <= 1'b0;
         m_done     <= 1'b0;
         m_wait     <= 1'b0;
         m_cd       <= 2'd0;
         m_idx      <= '0;
         m_req      <= 1'b0;
         m_flit     <= '0;
      end else begin
         m_ack_prev <= ch_ack;
         if (m_done) begin
            if (!pkt_req) begin
               m_done <= 1'b0;
               m_idx  <= '0;
            end
         end else if (m_wait) begin
            if (ch_ack != m_ack_prev) begin
               m_wait <= 1'b0;
               if (int'(m_idx) == NFLIT - 1) begin
                  m_done <= 1'b1;
               end else begin
                  m_idx <= m_idx + 4'd1;
                  m_cd  <= 2'd2;
               end
            end
         end else if (m_cd != 2'd0) begin
            m_cd <= m_cd - 2'd1;
            if (m_cd == 2'd1) begin
               m_req  <= ~m_req;
               m_flit <= mem[m_idx[BUFF_BITS-1:0]];
               m_wait <= 1'b1;
            end
         end else if (pkt_req) begin
            m_idx <= '0;
            m_cd  <= 2'd2;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model (or reset values).
   task automatic compare();
      if (!reset) begin
         chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
         chk("rst_buf_addr", {29'd0, buf_addr}, 32'd0);
         chk("rst_ch_req",   {31'd0, ch_req},   32'd0);
         chk("rst_ch_flit",  {24'd0, ch_flit},  32'd0);
      end else begin
         chk("pkt_done", {31'd0, pkt_done}, {31'd0, m_done});
         chk("buf_addr", {29'd0, buf_addr}, {29'd0, m_idx[BUFF_BITS-1:0]});
         chk("ch_req",   {31'd0, ch_req},   {31'd0, m_req});
         if (m_wait) chk("ch_flit", {24'd0, ch_flit}, {24'd0, m_flit});
      end
      if (reset && ch_req != mon_prev) got.push_back(ch_flit);
      mon_prev = reset ? ch_req : 1'b0;
   endtask

   // One clock: drive responder after the edge, compare on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (inject_ack) begin
         ch_ack     = ~ch_ack;
         inject_ack = 1'b0;
      end
      if (!reset) begin
         resp_seen = 1'b0;
         resp_cnt  = 0;
      end else begin
         if (ch_req != resp_seen) begin
            resp_seen = ch_req;
            resp_cnt  = ack_delay;
         end
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) ch_ack = ~ch_ack;
         end
      end
      @(negedge clk);
      compare();
   endtask

   task automatic wait_flits(input int n, input int budget);
      int k = 0;
      while (got.size() < n && k < budget) begin
         step();
         k++;
      end
      chk("wait_flits_timeout", {31'd0, got.size() >= n}, 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (pkt_done !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      chk("wait_done_timeout", {31'd0, pkt_done}, 32'd1);
   endtask

   task automatic check_seq(input string name, input logic [SIZE-1:0] exp [NFLIT]);
      chk({name, "_count"}, got.size(), NFLIT);
      for (int i = 0; i < NFLIT; i++) begin
         if (i < got.size()) chk($sformatf("%s_flit%0d", name, i), {24'd0, got[i]}, {24'd0, exp[i]});
      end
   endtask

   initial begin
      reset   = 1'b0;
      pkt_req = 1'b0;
      ch_ack  = 1'b0;
      for (int i = 0; i < NFLIT; i++) mem[i] = exp1[i];
      repeat (3) step();
      reset = 1'b1;
      repeat (2) step();

      // Packet with prompt acks, then hold pkt_req high after completion.
      ack_delay = 1;
      got.delete();
      pkt_req = 1'b1;
      wait_done(200);
      check_seq("t1", exp1);
      repeat (5) step();
      chk("t1_done_held", {31'd0, pkt_done}, 32'd1);
      chk("t1_addr_held", {29'd0, buf_addr}, 32'd7);
      pkt_req = 1'b0;
      step();
      chk("t1_done_clear", {31'd0, pkt_done}, 32'd0);
      chk("t1_addr_clear", {29'd0, buf_addr}, 32'd0);

      // Spurious ack while idle: no channel activity.
      got.delete();
      inject_ack = 1'b1;
      repeat (5) step();
      chk("t2_no_toggle", got.size(), 32'd0);
      chk("t2_req_idle",  {31'd0, ch_req}, 32'd0);

      // Slow responder: flit and request held for the whole ack latency.
      for (int i = 0; i < NFLIT; i++) mem[i] = exp2[i];
      ack_delay = 10;
      got.delete();
      pkt_req = 1'b1;
      wait_flits(1, 20);
      repeat (9) step();
      chk("t3_single_toggle", got.size(), 32'd1);
      chk("t3_flit_held", {24'd0, ch_flit}, 32'hA5);
      chk("t3_req_held",  {31'd0, ch_req}, 32'd1);
      wait_done(300);
      check_seq("t3", exp2);
      pkt_req = 1'b0;
      repeat (2) step();

      // Reset in the middle of a packet, then restart from flit 0.
      for (int i = 0; i < NFLIT; i++) mem[i] = exp1[i];
      ack_delay = 1;
      got.delete();
      pkt_req = 1'b1;
      wait_flits(4, 40);
      repeat (2) step();
      chk("t4_addr_before_rst", {29'd0, buf_addr}, 32'd4);
      reset  = 1'b0;
      ch_ack = 1'b0;
      step();
      chk("t4_rst_flit", {24'd0, ch_flit}, 32'd0);
      chk("t4_rst_addr", {29'd0, buf_addr}, 32'd0);
      step();
      got.delete();
      reset = 1'b1;
      wait_done(200);
      check_seq("t4", exp1);
      pkt_req = 1'b0;
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
